muldiv_ctrl: RTL
================

Name: muldiv_ctrl

Overview:
Multi-cycle multiply/divide sequencer that sits beside the execute stage and owns all HI/LO-producing arithmetic (MULT, MULTU, DIV, DIVU). It accepts an operation from execute and runs an iterative shift-add multiplier or restoring divider. While running it holds the pipeline via stall_req, then presents the 64-bit result with a one-cycle HI/LO write strobe.

Parameters:
DATA_W, 32, operand width; iteration count equals DATA_W
DIV0_LO, 32'hFFFFFFFF, LO value written on divide-by-zero

Ports:
clk  input  1  clock
rstn  input  1  asynchronous active-low reset
start  input  1  request a new operation; sampled only in IDLE
op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
src1  input  DATA_W  rs operand (multiplicand / dividend)
src2  input  DATA_W  rt operand (multiplier / divisor)
flush  input  1  abort current operation (exception/branch flush)
stall_req  output  1  pipeline hold request
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle result-valid pulse
hi_out  output  DATA_W  HI result (product[63:32] / remainder)
lo_out  output  DATA_W  LO result (product[31:0] / quotient)
whilo_out  output  1  HI/LO write enable; equal to done

Behaviour:
- Reset is rstn, asynchronous, active-low; clock is clk. Reset forces state IDLE, counter 0, hi_out=0, lo_out=0, done=0, whilo_out=0, busy=0. Reset mid-operation discards the operation with no write.
- States:
  - IDLE: start=1 and flush=0 → latch op and operands, go to MUL or DIV. DIV/DIVU with src2==0 → go to DONE directly.
  - MUL / DIV: one iteration per cycle, counter 0..DATA_W-1; after iteration DATA_W-1 → DONE.
  - DONE: one cycle; done=1, whilo_out=1; then IDLE.
- Latency: start accepted at edge N → done high during cycle N+DATA_W+1 (33 cycles for DATA_W=32). Divide-by-zero → done during cycle N+1.
- Signed ops:
  - Operands converted to magnitude at capture; sign corrected when entering DONE.
  - Product negated if operand signs differ.
  - Quotient negated if signs differ; remainder takes the dividend's sign.
  - Most-negative operand handled correctly: its magnitude is 2^31 in a DATA_W+1-bit internal register.
- Divide-by-zero: hi_out = src1 as captured (unsigned), lo_out = DIV0_LO, regardless of signedness.
- stall_req = (state==IDLE && start && !flush) || state==MUL || state==DIV. Low in DONE, so the pipeline advances in the same cycle the result is written.
- hi_out/lo_out update only on entry to DONE and hold their last values otherwise, including after flush.
- start while busy is ignored (no queueing).
- flush in any non-IDLE state → IDLE next edge; no done, no whilo_out, hi/lo unchanged. flush in DONE suppresses done/whilo_out that cycle. flush with start in IDLE → start ignored.

Test Plan:
- MULT src1=FFFFFFFD (-3), src2=00000005 → done at cycle 33 after start; hi=FFFFFFFF, lo=FFFFFFF1; stall_req high cycles 0..32, low at 33.
- MULTU FFFFFFFF × FFFFFFFF → hi=FFFFFFFE, lo=00000001, whilo_out single-cycle pulse.
- DIV FFFFFFF9 (-7) / 00000002 → lo=FFFFFFFD, hi=FFFFFFFF. DIV 80000000 / FFFFFFFF → lo=80000000, hi=0.
- DIVU 0000000A / 0 → done one cycle after start; hi=0000000A, lo=FFFFFFFF.
- Start MULTU 2×3 (hi=0, lo=6). Assert flush at iteration 10 of a DIVU 100/7 → busy drops next cycle, no done, hi/lo still 0/6. A start pulse during busy is ignored.
- Deassert rstn at iteration 20 of MULT → all outputs 0 immediately. After release, a fresh DIVU 100/7 → lo=0000000E, hi=00000002.

Source files
------------

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: multi-cycle multiply/divide sequencer for HI/LO arithmetic.
//
// Runs MULT/MULTU through a DATA_W-step shift-add multiplier.
// Runs DIV/DIVU through a DATA_W-step restoring divider.
// Signed operands are reduced to magnitudes at capture.
// The sign is restored as the result is written on entry to DONE.
//
// Ports:
//   clk, rstn   clock, asynchronous active-low reset
//   start       request a new operation (only honoured in IDLE)
//   op          00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   src1, src2  rs (multiplicand / dividend), rt (multiplier / divisor)
//   flush       abort the operation in flight
//   stall_req   hold the pipeline while an operation is being accepted or run
//   busy        high in any state other than IDLE
//   done        one-cycle result-valid pulse
//   hi_out      product[2W-1:W] or remainder
//   lo_out      product[W-1:0] or quotient
//   whilo_out   HI/LO write enable, identical to done
module muldiv_ctrl #(
   parameter int                DATA_W  = 32,
   parameter logic [DATA_W-1:0] DIV0_LO = 32'hFFFFFFFF
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              start,
   input  logic [1:0]        op,
   input  logic [DATA_W-1:0] src1,
   input  logic [DATA_W-1:0] src2,
   input  logic              flush,
   output logic              stall_req,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] hi_out,
   output logic [DATA_W-1:0] lo_out,
   output logic              whilo_out
);

   localparam int CNT_W = $clog2(DATA_W);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

   // Magnitude in DATA_W+1 bits, so the most-negative operand maps to 2^(W-1).
   function automatic logic [DATA_W:0] to_mag(input logic [DATA_W-1:0] v, input logic sgn);
      logic [DATA_W:0] x;
      x = {v[DATA_W-1] & sgn, v};
      return (sgn && v[DATA_W-1]) ? (~x + 1'b1) : x;
   endfunction

   function automatic logic [DATA_W-1:0] cond_neg(input logic [DATA_W-1:0] v, input logic n);
      return n ? (~v + 1'b1) : v;
   endfunction

   function automatic logic [2*DATA_W-1:0] cond_neg2(input logic [2*DATA_W-1:0] v, input logic n);
      return n ? (~v + 1'b1) : v;
   endfunction

   state_t             state_r, state_nxt;
   logic [CNT_W-1:0]   cnt_r;
   logic               is_div_r, neg_res_r, neg_rem_r;
   logic [DATA_W:0]    rem_r;      // upper half: partial product / partial remainder
   logic [DATA_W-1:0]  q_r;        // lower half: multiplier bits / quotient bits
   logic [DATA_W:0]    b_r;        // multiplicand / divisor magnitude

   logic               accept, div0, last_iter, op_signed;
   logic [DATA_W:0]    mag1, mag2;
   logic [DATA_W:0]    rem_sh, add_sum, rem_n;
   logic signed [DATA_W+1:0] diff;
   logic               ge;
   logic [DATA_W-1:0]  q_n;
   logic [2*DATA_W-1:0] prod;

   assign op_signed = ~op[0];
   assign mag1      = to_mag(src1, op_signed);
   assign mag2      = to_mag(src2, op_signed);
   assign accept    = (state_r == S_IDLE) && start && !flush;
   assign div0      = op[1] && (src2 == '0);
   assign last_iter = ((state_r == S_MUL) || (state_r == S_DIV)) && !flush &&
                      (cnt_r == CNT_W'(DATA_W - 1));

   // One iteration of either engine; the active one is chosen by is_div_r.
   assign rem_sh  = {rem_r[DATA_W-1:0], q_r[DATA_W-1]};
   assign diff    = $signed({1'b0, rem_sh}) - $signed({1'b0, b_r});
   assign ge      = !diff[DATA_W+1];
   assign add_sum = rem_r + (q_r[0] ? b_r : '0);

   always_comb begin
      rem_n = {1'b0, add_sum[DATA_W:1]};
      q_n   = {add_sum[0], q_r[DATA_W-1:1]};
      if (is_div_r) begin
         rem_n = ge ? diff[DATA_W:0] : rem_sh;
         q_n   = {q_r[DATA_W-2:0], ge};
      end
   end

   assign prod = cond_neg2({rem_n[DATA_W-1:0], q_n}, neg_res_r);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state_r <= S_IDLE;
      else       state_r <= state_nxt;
   end

   always_comb begin
      state_nxt = state_r;
      case (state_r)
         S_IDLE:  if (accept) state_nxt = div0 ? S_DONE : (op[1] ? S_DIV : S_MUL);
         S_MUL,
         S_DIV:   if (flush) state_nxt = S_IDLE;
                  else if (cnt_r == CNT_W'(DATA_W - 1)) state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt_r     <= '0;
         is_div_r  <= 1'b0;
         neg_res_r <= 1'b0;
         neg_rem_r <= 1'b0;
      end else if (accept) begin
         cnt_r     <= '0;
         is_div_r  <= op[1];
         neg_res_r <= op_signed && (src1[DATA_W-1] ^ src2[DATA_W-1]);
         neg_rem_r <= op_signed && src1[DATA_W-1];
      end else if (((state_r == S_MUL) || (state_r == S_DIV)) && !flush) begin
         cnt_r <= cnt_r + 1'b1;
      end else begin
         cnt_r <= '0;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         rem_r <= '0;
         q_r   <= op[1] ? mag1[DATA_W-1:0] : mag2[DATA_W-1:0];
         b_r   <= op[1] ? mag2 : mag1;
      end else if ((state_r == S_MUL) || (state_r == S_DIV)) begin
         rem_r <= rem_n;
         q_r   <= q_n;
      end
   end

   // HI/LO change only when DONE is entered; divide-by-zero bypasses the engine.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         hi_out <= '0;
         lo_out <= '0;
      end else if (accept && div0) begin
         hi_out <= src1;
         lo_out <= DIV0_LO;
      end else if (last_iter) begin
         if (is_div_r) begin
            hi_out <= cond_neg(rem_n[DATA_W-1:0], neg_rem_r);
            lo_out <= cond_neg(q_n, neg_res_r);
         end else begin
            hi_out <= prod[2*DATA_W-1:DATA_W];
            lo_out <= prod[DATA_W-1:0];
         end
      end
   end

   // stall_req drops in DONE so the pipeline advances while HI/LO are written.
   assign stall_req = accept || (state_r == S_MUL) || (state_r == S_DIV);
   assign busy      = (state_r != S_IDLE);
   assign done      = (state_r == S_DONE) && !flush;
   assign whilo_out = done;

endmodule
